// File: rtl/sync_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_buf
// Description : Single-clock FIFO with registered read data and registered
//               status flags (full / empty / almost_full / almost_empty),
//               plus one-cycle overflow / underflow error pulses and a
//               synchronous flush. Storage is a DEPTH x DATA_WIDTH array
//               that is never reset; only pointers, count and outputs are.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wclk         in   1            clock, all state changes on rising edge
//   wrst_n       in   1            asynchronous active-low reset
//   flush        in   1            synchronous clear of pointers and count
//   wr_en        in   1            write request
//   wdata        in   DATA_WIDTH   write data
//   rd_en        in   1            read request
//   rdata        out  DATA_WIDTH   registered read data (holds when idle)
//   rd_valid     out  1            rdata carries a word popped last edge
//   full         out  1            count == DEPTH
//   empty        out  1            count == 0
//   almost_full  out  1            count >= AF_LEVEL
//   almost_empty out  1            count <= AE_LEVEL
//   count        out  ADDR_WIDTH+1 stored words, 0..DEPTH
//   overflow     out  1            pulse: write attempted while full
//   underflow    out  1            pulse: read attempted while empty
// ============================================================================
module sync_fifo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  // almost_full out of reset: only a zero threshold makes an empty FIFO
  // "almost full"; almost_empty is always true at count 0.
  localparam logic                AF_RST    = (AF_LEVEL == 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q,  wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q,  rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q,  full_d;
  logic                  empty_q, empty_d;
  logic                  af_q,    af_d;
  logic                  ae_q,    ae_d;
  logic                  ovf_q,   ovf_d;
  logic                  udf_q,   udf_d;

  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // --------------------------------------------------------------------------
  // Acceptance. Decisions use the registered flags, so a write to a full
  // FIFO is refused even when a read frees a slot on the same edge, and a
  // read from an empty FIFO is never satisfied by a same-cycle write.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_acc = wr_en & ~full_q  & ~flush;
    w_rd_acc = rd_en & ~empty_q & ~flush;
  end

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    rd_valid_d = w_rd_acc;
    ovf_d      = wr_en & full_q  & ~flush;
    udf_d      = rd_en & empty_q & ~flush;

    if (flush) begin
      // rdata deliberately keeps its last value across a flush.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_wr_acc) begin
        wptr_d = wptr_q + PTR_ONE;   // DEPTH is a power of two: wraps freely
      end
      if (w_rd_acc) begin
        rptr_d  = rptr_q + PTR_ONE;
        rdata_d = mem_q[rptr_q];
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Flags are computed from the post-update count so they line up with
    // the count output in the same cycle.
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
  end

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= AF_RST;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: no reset, written only on an accepted write. A read and
  // write never target the same slot in one cycle (that would need count
  // to be both 0 and DEPTH), so no read/write collision handling is needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (w_wr_acc) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rdata        = rdata_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_buf
// Description : Directed self-checking bench for sync_fifo_buf (defaults:
//               8-bit data, depth 8, AF_LEVEL 6, AE_LEVEL 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_buf;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int DEP = 8;
  localparam int AFL = 6;
  localparam int AEL = 2;

  logic          wclk;
  logic          wrst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int total;
  int bad;

  sync_fifo_buf #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AFL),
    .AE_LEVEL   (AEL)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Status flags expected for a given occupancy.
  task automatic chk_flags(input string tag, input int n);
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_full"},  32'(full),         32'(n == DEP));
    chk({tag, "_empty"}, 32'(empty),        32'(n == 0));
    chk({tag, "_af"},    32'(almost_full),  32'(n >= AFL));
    chk({tag, "_ae"},    32'(almost_empty), 32'(n <= AEL));
  endtask

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;
  bit            do_wr;
  bit            do_rd;
  int            sent;
  int            recv;
  int            mcnt;

  initial begin
    total  = 0;
    bad    = 0;
    flush  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wdata  = '0;
    wrst_n = 1'b1;
    #2 wrst_n = 1'b0;
    tick;
    tick;

    // ---- reset state
    chk_flags("rst", 0);
    chk("rst_rdata",     32'(rdata),     32'h0);
    chk("rst_rd_valid",  32'(rd_valid),  32'h0);
    chk("rst_overflow",  32'(overflow),  32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    wrst_n = 1'b1;
    tick;
    chk_flags("post_rst", 0);

    // ---- fill 0x11..0x18
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wdata = 8'h11 + 8'(i);
      tick;
      chk_flags("fill", i + 1);
      chk("fill_ovf", 32'(overflow), 32'h0);
    end
    wr_en = 1'b0;

    // ---- drain, expect order and one-cycle latency
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick;
      chk("drain_data", 32'(rdata),    32'(8'h11 + 8'(i)));
      chk("drain_rv",   32'(rd_valid), 32'h1);
      chk_flags("drain", 7 - i);
    end
    rd_en = 1'b0;
    tick;
    chk("idle_rv",    32'(rd_valid), 32'h0);
    chk("idle_hold",  32'(rdata),    32'h18);

    // ---- refill, then write+read while full
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wdata = 8'h21 + 8'(i);
      tick;
    end
    chk_flags("refill", 8);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h99;
    tick;
    chk("full_both_ovf",  32'(overflow),  32'h1);
    chk("full_both_data", 32'(rdata),     32'h21);
    chk("full_both_rv",   32'(rd_valid),  32'h1);
    chk_flags("full_both", 7);
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick;
    chk("ovf_pulse_end", 32'(overflow), 32'h0);
    chk("ovf_rv_end",    32'(rd_valid), 32'h0);
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1;
      tick;
      chk("drain2_data", 32'(rdata), 32'(8'h22 + 8'(i)));
    end
    chk_flags("drain2", 0);

    // ---- write+read while empty
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h3C;
    tick;
    chk("empty_both_udf",  32'(underflow), 32'h1);
    chk("empty_both_rv",   32'(rd_valid),  32'h0);
    chk("empty_both_data", 32'(rdata),     32'h28);
    chk_flags("empty_both", 1);
    wr_en = 1'b0;
    tick;
    chk("late_read_data", 32'(rdata),     32'h3C);
    chk("late_read_rv",   32'(rd_valid),  32'h1);
    chk("udf_pulse_end",  32'(underflow), 32'h0);
    chk_flags("late_read", 0);
    rd_en = 1'b0;

    // ---- stream 20 words across pointer wrap
    sent = 0;
    recv = 0;
    mcnt = 0;
    for (int c = 0; c < 200 && recv < 20; c++) begin
      do_wr = (sent < 20) && ((c % 4) != 3) && (mcnt < DEP);
      do_rd = (mcnt > 0) && (((c % 2) == 1) || (sent >= 20));
      wr_en = do_wr;
      rd_en = do_rd;
      wdata = 8'h40 + 8'(sent);
      if (do_rd) exp_word = exp_q.pop_front();
      if (do_wr) begin
        exp_q.push_back(wdata);
        sent++;
      end
      mcnt = mcnt + int'(do_wr) - int'(do_rd);
      tick;
      chk("stream_count", 32'(count),    32'(mcnt));
      chk("stream_rv",    32'(rd_valid), 32'(do_rd));
      if (do_rd) begin
        chk("stream_data", 32'(rdata), 32'(exp_word));
        recv++;
      end
    end
    chk("stream_done", 32'(recv), 32'd20);
    wr_en = 1'b0;
    rd_en = 1'b0;

    // ---- flush at count 5 with both requests high
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wdata = 8'h61 + 8'(i);
      tick;
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick;
    chk("pre_flush_data", 32'(rdata), 32'h61);
    chk_flags("pre_flush", 5);
    flush = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'hEE;
    tick;
    chk_flags("flush", 0);
    chk("flush_rv",    32'(rd_valid),  32'h0);
    chk("flush_rdata", 32'(rdata),     32'h61);
    chk("flush_ovf",   32'(overflow),  32'h0);
    chk("flush_udf",   32'(underflow), 32'h0);
    flush = 1'b0;
    wr_en = 1'b0;
    tick;
    chk("post_flush_udf",  32'(underflow), 32'h1);
    chk("post_flush_rv",   32'(rd_valid),  32'h0);
    chk("post_flush_data", 32'(rdata),     32'h61);
    rd_en = 1'b0;

    // ---- asynchronous reset mid-operation at count 4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wdata = 8'h71 + 8'(i);
      tick;
    end
    wr_en = 1'b0;
    chk_flags("pre_areset", 4);
    #3 wrst_n = 1'b0;
    #1;
    chk_flags("areset", 0);
    chk("areset_rdata", 32'(rdata),    32'h0);
    chk("areset_rv",    32'(rd_valid), 32'h0);
    tick;
    wrst_n = 1'b1;
    wr_en  = 1'b1;
    wdata  = 8'hA5;
    tick;
    chk_flags("after_rel_wr", 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick;
    chk("after_rel_data", 32'(rdata),    32'hA5);
    chk("after_rel_rv",   32'(rd_valid), 32'h1);
    chk_flags("after_rel_rd", 0);
    rd_en = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
